// File: rtl/twos_to_sign_mag_pkg.sv
// Shared multiplier definitions: converter state encoding and default datapath widths.
package twos_to_sign_mag_pkg;

    localparam int unsigned MANT_W  = 25;
    localparam int unsigned EXP_W   = 10;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : twos_to_sign_mag_pkg

// File: rtl/twos_to_sign_mag_serial_negate_cell.sv
// One bit of an LSB-first two's-complement negation: copy bits up to and including
// the first 1, invert everything after it.
module twos_to_sign_mag_serial_negate_cell (
    input  logic b,
    input  logic seen_one,
    input  logic neg,
    output logic o,
    output logic seen_one_next
);

    always_comb begin
        o             = (neg && seen_one) ? ~b : b;
        seen_one_next = seen_one | b;
    end

endmodule : twos_to_sign_mag_serial_negate_cell

// File: rtl/twos_to_sign_mag.sv
// Serial two's-complement to sign-magnitude converter; negates one bit per clock,
// LSB first, so no wide carry chain is needed.
module twos_to_sign_mag
    import twos_to_sign_mag_pkg::*;
#(
    parameter int unsigned W = MANT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         out_is_min
);

    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    state_t             state, state_next;
    logic [W-1:0]       sr, sr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               sign_q, sign_next;
    logic               min_q, min_next;
    logic               seen_one, seen_next;
    logic               in_ready_next;
    logic               out_valid_next;
    logic               out_sign_next;
    logic [W-1:0]       out_mag_next;
    logic               out_is_min_next;
    logic               cell_o;
    logic               cell_seen_next;

    twos_to_sign_mag_serial_negate_cell u_cell (
        .b             (sr[0]),
        .seen_one      (seen_one),
        .neg           (sign_q),
        .o             (cell_o),
        .seen_one_next (cell_seen_next)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sr         <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            min_q      <= 1'b0;
            seen_one   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_mag    <= '0;
            out_is_min <= 1'b0;
        end else begin
            state      <= state_next;
            sr         <= sr_next;
            cnt        <= cnt_next;
            sign_q     <= sign_next;
            min_q      <= min_next;
            seen_one   <= seen_next;
            in_ready   <= in_ready_next;
            out_valid  <= out_valid_next;
            out_sign   <= out_sign_next;
            out_mag    <= out_mag_next;
            out_is_min <= out_is_min_next;
        end
    end

    // Next-state and next-output logic; outputs are precomputed so they land with the state
    always_comb begin
        state_next      = state;
        sr_next         = sr;
        cnt_next        = cnt;
        sign_next       = sign_q;
        min_next        = min_q;
        seen_next       = seen_one;
        in_ready_next   = in_ready;
        out_valid_next  = out_valid;
        out_sign_next   = out_sign;
        out_mag_next    = out_mag;
        out_is_min_next = out_is_min;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    sr_next       = in_data;
                    sign_next     = in_data[W-1];
                    min_next      = (in_data == MIN_VAL);
                    cnt_next      = '0;
                    seen_next     = 1'b0;
                    in_ready_next = 1'b0;
                    state_next    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_next   = {cell_o, sr[W-1:1]};
                seen_next = cell_seen_next;
                if (cnt == LAST_CNT) begin
                    state_next      = ST_DONE;
                    out_valid_next  = 1'b1;
                    out_sign_next   = sign_q;
                    out_mag_next    = {cell_o, sr[W-1:1]};
                    out_is_min_next = min_q;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                out_valid_next = 1'b0;
                in_ready_next  = 1'b1;
            end
        endcase
    end

endmodule : twos_to_sign_mag

// File: tb/tb_twos_to_sign_mag.sv
// Scoreboard bench for the serial two's-complement to sign-magnitude converter (W=25 and W=8).
module tb_twos_to_sign_mag;
    import twos_to_sign_mag_pkg::*;

    localparam int unsigned WA = MANT_W;
    localparam int unsigned WB = 8;

    typedef struct {
        logic        sign;
        logic [31:0] mag;
        logic        is_min;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic          in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic          out_sign_a, out_is_min_a;
    logic [WA-1:0] in_data_a, out_mag_a;
    logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic          out_sign_b, out_is_min_b;
    logic [WB-1:0] in_data_b, out_mag_b;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;

    twos_to_sign_mag #(.W(WA)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_sign(out_sign_a), .out_mag(out_mag_a), .out_is_min(out_is_min_a)
    );

    twos_to_sign_mag #(.W(WB)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sign(out_sign_b), .out_mag(out_mag_b), .out_is_min(out_is_min_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic negation of a w-bit two's-complement word
    function automatic exp_t ref_model(input int w, input logic [31:0] d);
        exp_t        e;
        logic [31:0] mask;
        mask     = (32'd1 << w) - 32'd1;
        e.sign   = d[w-1];
        e.mag    = e.sign ? ((~d + 32'd1) & mask) : (d & mask);
        e.is_min = ((d & mask) == (32'd1 << (w - 1)));
        return e;
    endfunction

    task automatic run_a(input logic [WA-1:0] d, input int stall);
        exp_t e;
        int   k;
        @(negedge clk);
        out_ready_a = (stall == 0);
        in_data_a   = d;
        in_valid_a  = 1'b1;
        check_eq("a_in_ready_idle", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        sb_a.push_back(ref_model(WA, 32'(d)));
        @(negedge clk);
        in_valid_a = 1'b0;
        in_data_a  = ~d;
        check_eq("a_in_ready_busy", 32'(in_ready_a), 32'd0);
        k = 0;
        while (!out_valid_a && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("a_latency", 32'(k), 32'(WA));
        if (!out_valid_a) begin
            sb_a.delete();
            return;
        end
        e = sb_a.pop_front();
        check_eq("a_sign", 32'(out_sign_a), 32'(e.sign));
        check_eq("a_mag", 32'(out_mag_a), e.mag);
        check_eq("a_is_min", 32'(out_is_min_a), 32'(e.is_min));
        for (int i = 0; i < stall; i++) begin
            check_eq("a_hold_valid", 32'(out_valid_a), 32'd1);
            check_eq("a_hold_mag", 32'(out_mag_a), e.mag);
            check_eq("a_hold_in_ready", 32'(in_ready_a), 32'd0);
            @(negedge clk);
        end
        out_ready_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("a_valid_drop", 32'(out_valid_a), 32'd0);
        check_eq("a_in_ready_back", 32'(in_ready_a), 32'd1);
    endtask

    task automatic run_b(input logic [WB-1:0] d, input bit chk_lat);
        exp_t e;
        int   k;
        @(negedge clk);
        out_ready_b = 1'b1;
        in_data_b   = d;
        in_valid_b  = 1'b1;
        @(posedge clk);
        sb_b.push_back(ref_model(WB, 32'(d)));
        @(negedge clk);
        in_valid_b = 1'b0;
        k = 0;
        while (!out_valid_b && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (chk_lat || !out_valid_b)
            check_eq("b_latency", 32'(k), 32'(WB));
        if (!out_valid_b) begin
            sb_b.delete();
            return;
        end
        e = sb_b.pop_front();
        check_eq("b_sign", 32'(out_sign_b), 32'(e.sign));
        check_eq("b_mag", 32'(out_mag_b), e.mag);
        check_eq("b_is_min", 32'(out_is_min_b), 32'(e.is_min));
        @(posedge clk);
    endtask

    task automatic abort_test();
        int n_valid;
        @(negedge clk);
        out_ready_a = 1'b1;
        in_data_a   = 25'h1FFFFFB;
        in_valid_a  = 1'b1;
        @(posedge clk);
        sb_a.push_back(ref_model(WA, 32'h1FFFFFB));
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        sb_a.delete();
        check_eq("rst_in_ready", 32'(in_ready_a), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_sign", 32'(out_sign_a), 32'd0);
        check_eq("rst_mag", 32'(out_mag_a), 32'd0);
        check_eq("rst_is_min", 32'(out_is_min_a), 32'd0);
        @(negedge clk);
        rst_a   = 1'b0;
        n_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_a) n_valid++;
        end
        check_eq("abort_no_output", 32'(n_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;  rst_b = 1'b1;
        in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
        @(negedge clk);
        check_eq("reset_in_ready", 32'(in_ready_a), 32'd1);
        check_eq("reset_out_valid", 32'(out_valid_a), 32'd0);
        check_eq("reset_sign", 32'(out_sign_a), 32'd0);
        check_eq("reset_mag", 32'(out_mag_a), 32'd0);
        check_eq("reset_is_min", 32'(out_is_min_a), 32'd0);
        check_eq("reset_b_in_ready", 32'(in_ready_b), 32'd1);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        run_a(25'h0000005, 0);
        run_a(25'h1FFFFFB, 0);
        run_a(25'h1FFFFFF, 0);
        run_a(25'h1000000, 0);
        run_a(25'h0000000, 0);
        run_a(25'h0FFFFFF, 0);
        run_a(25'h1000001, 0);
        run_a(25'h1FFFFFB, 10);
        abort_test();
        run_a(25'h1FFFFF6, 0);

        run_b(8'h80, 1'b1);
        run_b(8'h7F, 1'b1);
        for (int i = 0; i < 200; i++)
            run_b(8'($urandom()), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_twos_to_sign_mag

// File: doc/twos_to_sign_mag.md
Name: twos_to_sign_mag

Overview:
Serial converter from two's-complement to sign-magnitude. This is the inverse of the multiplier's sign-magnitude to two's-complement negators. It takes a W-bit two's-complement word under a valid/ready handshake and returns a sign bit plus an unsigned W-bit magnitude. It negates one bit per clock, LSB first, so the multiplier datapath can re-pack products or exponents without a wide carry chain.

Parameters:
W, 25, data width in bits; must be ≥ 2 (the 10/9/8-bit exponent paths instantiate it with W=10/9/8)

Ports:
clk  input  1  single clock for all state
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word
in_data  input  W  two's-complement operand
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
out_sign  output  1  sign of the operand (in_data[W-1])
out_mag  output  W  unsigned magnitude |in_data|
out_is_min  output  1  operand was -2^(W-1), so the magnitude is not representable as a positive W-bit signed value

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_is_min=0.
  - Bit counter, shift register and seen_one flag are cleared.
- States: IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - Latch in_data into shift register sr.
    - Latch sign = in_data[W-1].
    - Set min_flag = (in_data == {1'b1, {W-1{1'b0}}}).
    - Set cnt=0, seen_one=0, then go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle processes b = sr[0]:
    - If sign=0: o = b.
    - If sign=1: o = seen_one ? ~b : b, then seen_one <= seen_one | b.
  - sr <= {o, sr[W-1:1]}; cnt <= cnt+1.
  - When cnt == W-1, the update completes and the next state is DONE.
- DONE:
  - out_valid=1.
  - out_mag=sr, out_sign=sign, out_is_min=min_flag; all held stable while out_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: acceptance at edge t gives out_valid=1 from edge t+W.
  - Minimum issue interval is W+2 cycles: one IDLE bubble after each output handshake.
  - No input/output overlap.
- Counter width is $clog2(W); it never wraps, because it is reset on every acceptance.
- Arithmetic rules:
  - Positive operands and zero pass through unchanged, with identical latency.
  - Zero gives sign=0, mag=0.
  - -2^(W-1) gives sign=1, mag=2^(W-1), out_is_min=1.
- in_valid is ignored outside IDLE; the upstream must hold data until in_ready.
- in_data changes while in SHIFT have no effect.
- Reset mid-SHIFT or mid-DONE aborts the conversion; no output is produced for the aborted word.
- out_ready asserted in IDLE or SHIFT has no effect.

Decomposition:
- Shared multiplier package holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default widths MANT_W=25, EXP_W=10.
- One natural leaf sub-module: serial_negate_cell. Pure combinational; inputs b, seen_one, neg; outputs o, seen_one_next.
- The FSM, counter and shift register stay in the top module.

Test Plan (W=25 unless stated):
- in_data=25'h0000005, out_ready=1 → out_valid exactly 25 cycles after acceptance; sign=0, mag=25'h0000005, is_min=0.
- in_data=25'h1FFFFFB (-5) → sign=1, mag=25'h0000005; in_data=25'h1FFFFFF (-1) → sign=1, mag=25'h0000001.
- in_data=25'h1000000 → sign=1, mag=25'h1000000, is_min=1; in_data=0 → sign=0, mag=0, is_min=0.
- Backpressure: -5 accepted with out_ready=0 for 10 cycles → out_valid stays 1 and mag stays 5 throughout, in_ready=0; on out_ready=1 → in_ready=1 the following cycle.
- rst pulsed asynchronously (mid-clock) at cycle 12 of SHIFT → all outputs 0 and in_ready=1 immediately; no out_valid follows. Next word 25'h1FFFFF6 → mag=10.
- W=8 instance: 8'h80 → sign=1, mag=8'h80, is_min=1, latency 8; 200 random values checked against a reference negation.
